tristate_rx: RTL and testbench
==============================

Name: tristate_rx

Overview:
- Receive-side companion to the registered tristate output path. It samples a shared bidirectional/tristate line through the pad input buffer, but only after the local driver has released the line and a turnaround interval has elapsed.
- Resynchronizes and glitch-filters the line and reports the settled level.
- Queues each filtered edge as an event through a single-entry valid/ready handshake to fabric logic.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on PAD_IN (legal 2..4)
- FILTER_LEN, 3, consecutive differing samples required to accept a level change (legal 1..15)
- TURNAROUND, 2, cycles after LOCAL_OE deasserts before line is trusted (legal 1..15)

Ports:
- CLK  input  1  sole clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- PAD_IN  input  1  line value from pad I_BUF output, asynchronous to CLK
- LOCAL_OE  input  1  synchronous; 1 = this side drives the line (receiver ignores PAD_IN)
- RX_DATA  output  1  filtered line level
- RX_VALID  output  1  1 = line owned by far end and RX_DATA trustworthy
- EVT_VALID  output  1  edge event pending
- EVT_READY  input  1  consumer accepts event when EVT_VALID & EVT_READY
- EVT_RISE  output  1  pending event type: 1 rise, 0 fall
- EVT_OVERRUN  output  1  sticky: an edge was dropped while an event was pending

Behaviour:
- Reset (RST_N low, async): state=DRIVE, sync chain=0, filter count=0, RX_DATA=0, RX_VALID=0, EVT_VALID=0, EVT_RISE=0, EVT_OVERRUN=0. Release is synchronous to CLK by the integrator.
- Sync chain always runs; SYNC_OUT = last stage.
- FSM states:
  - DRIVE: RX_VALID=0, filter held. LOCAL_OE=0 -> TURN, turnaround count loaded with TURNAROUND-1.
  - TURN: RX_VALID=0; count decrements each cycle. LOCAL_OE=1 -> DRIVE. Count==0 -> LISTEN; on the same edge RX_DATA is preloaded with SYNC_OUT and the filter count cleared. No event is generated on preload.
  - LISTEN: RX_VALID=1. LOCAL_OE=1 -> DRIVE; RX_VALID is 0 on the next cycle and RX_DATA holds its last value.
- Any state: LOCAL_OE=1 forces DRIVE on the next edge. It has priority over turnaround expiry.
- Filter, LISTEN only:
  - SYNC_OUT==RX_DATA -> count=0.
  - Otherwise count++. When count reaches FILTER_LEN, RX_DATA toggles, count=0, and an edge event fires.
- Latency: a clean PAD_IN step is visible on RX_DATA SYNC_STAGES+FILTER_LEN cycles after the first sampling edge. EVT_VALID rises on the same edge as RX_DATA changes.
- Glitches shorter than FILTER_LEN cycles at SYNC_OUT produce no change and no event.
- Event register:
  - Edge with EVT_VALID=0: load EVT_RISE=new RX_DATA, EVT_VALID=1.
  - EVT_VALID&EVT_READY with no new edge: EVT_VALID=0 next cycle.
  - Accept and new edge on the same cycle: new event loads and EVT_VALID stays 1; no overrun.
  - Edge while EVT_VALID=1 and EVT_READY=0: edge dropped, held event unchanged, EVT_OVERRUN=1.
- EVT_OVERRUN clears on the cycle after the next accepted handshake.
- Pending events survive DRIVE/TURN transitions. Only reset clears them.

Optional Feature:
- Macro TRISTATE_RX_EDGE_CNT_EN.
- Defined: adds output EDGE_CNT [15:0], reset 0. It increments on every filtered edge, including dropped ones, and wraps 0xFFFF->0x0000.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tristate_rx_pkg: state enum (DRIVE, TURN, LISTEN), parameter defaults, legal-range constants, EDGE_CNT width constant (16).
- Sub-module tristate_rx_filter: sync chain plus glitch filter, with preload/enable inputs, RX_DATA and edge-pulse outputs. The top level holds the FSM, event register and optional counter.

Test Plan:
- Reset, LOCAL_OE=0, PAD_IN=1 -> RX_VALID rises after TURNAROUND=2 cycles with RX_DATA=1 and no EVT_VALID.
- In LISTEN, PAD_IN 1->0 held -> RX_DATA=0 and EVT_VALID=1, EVT_RISE=0 exactly 5 cycles (2+3) after the step; EVT_READY=1 clears EVT_VALID the next cycle.
- PAD_IN pulses of 1 and 2 cycles -> RX_DATA unchanged, no event. A 3-cycle pulse -> rise then fall events.
- EVT_READY=0, two edges -> first event held (EVT_RISE=1), EVT_OVERRUN=1. Accept -> OVERRUN=0 the following cycle.
- LOCAL_OE=1 mid-filter (count=2), then 0 -> RX_VALID=0 for 3 cycles, RX_DATA preloaded, no spurious event.
- RST_N asserted asynchronously mid-cycle with EVT_VALID=1 -> all outputs 0 immediately. With TRISTATE_RX_EDGE_CNT_EN, 65536 edges -> EDGE_CNT=0.

Source files
------------

// File: rtl/tristate_rx_pkg.sv
// rtl/tristate_rx_pkg.sv - shared types and constants for the tristate receive path
package tristate_rx_pkg;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        TURN   = 2'd1,
        LISTEN = 2'd2
    } rx_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 3;
    localparam int TURNAROUND_DEF  = 2;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILTER_LEN_MIN  = 1;
    localparam int FILTER_LEN_MAX  = 15;
    localparam int TURNAROUND_MIN  = 1;
    localparam int TURNAROUND_MAX  = 15;

    // Wide enough for the largest legal FILTER_LEN and TURNAROUND.
    localparam int CNT_W      = 4;
    localparam int EDGE_CNT_W = 16;

endpackage

// File: rtl/tristate_rx_filter.sv
// rtl/tristate_rx_filter.sv - pad synchronizer and glitch filter with preload
module tristate_rx_filter
    import tristate_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_in,
    input  logic enable,
    input  logic preload,
    output logic rx_data,
    output logic edge_pulse
);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CNT_W-1:0]       count_q;
    logic                   differ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign differ     = sync_out ^ rx_data;
    // Combinational so the event register loads on the same edge rx_data toggles.
    assign edge_pulse = enable & differ & (count_q == FILT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data <= 1'b0;
            count_q <= '0;
        end else if (preload) begin
            rx_data <= sync_out;
            count_q <= '0;
        end else if (enable) begin
            if (!differ) begin
                count_q <= '0;
            end else if (count_q == FILT_LAST) begin
                rx_data <= ~rx_data;
                count_q <= '0;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tristate_rx.sv
// rtl/tristate_rx.sv - turnaround-gated tristate receiver with edge event handshake
// Optional EDGE_CNT output enabled by defining TRISTATE_RX_EDGE_CNT_EN.
module tristate_rx
    import tristate_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TURNAROUND  = TURNAROUND_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_in,
    input  logic local_oe,
    output logic rx_data,
    output logic rx_valid,
    output logic evt_valid,
    input  logic evt_ready,
    output logic evt_rise,
    output logic evt_overrun
`ifdef TRISTATE_RX_EDGE_CNT_EN
    ,
    output logic [EDGE_CNT_W-1:0] edge_cnt
`endif
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] turn_q, turn_d;
    logic             preload;
    logic             filt_en;
    logic             edge_pulse;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DRIVE;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        preload = 1'b0;
        case (state_q)
            DRIVE: begin
                if (!local_oe) begin
                    state_d = TURN;
                    turn_d  = TURN_LOAD;
                end
            end
            TURN: begin
                // Reclaiming the line wins over turnaround expiry.
                if (local_oe) begin
                    state_d = DRIVE;
                end else if (turn_q == '0) begin
                    state_d = LISTEN;
                    preload = 1'b1;
                end else begin
                    turn_d = turn_q - CNT_W'(1);
                end
            end
            LISTEN: begin
                if (local_oe) begin
                    state_d = DRIVE;
                end
            end
            default: state_d = DRIVE;
        endcase
    end

    assign rx_valid = (state_q == LISTEN);
    assign filt_en  = rx_valid & ~local_oe;

    tristate_rx_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_in     (pad_in),
        .enable     (filt_en),
        .preload    (preload),
        .rx_data    (rx_data),
        .edge_pulse (edge_pulse)
    );

    assign accept = evt_valid & evt_ready;

    // The new level after a filtered edge is the inverse of the current rx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid   <= 1'b0;
            evt_rise    <= 1'b0;
            evt_overrun <= 1'b0;
        end else begin
            if (edge_pulse && (!evt_valid || evt_ready)) begin
                evt_valid <= 1'b1;
                evt_rise  <= ~rx_data;
            end else if (accept) begin
                evt_valid <= 1'b0;
            end
            if (accept) begin
                evt_overrun <= 1'b0;
            end else if (edge_pulse && evt_valid) begin
                evt_overrun <= 1'b1;
            end
        end
    end

`ifdef TRISTATE_RX_EDGE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (edge_pulse) begin
            edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tristate_rx.sv
// tb/tb_tristate_rx.sv - scoreboard bench for tristate_rx (optional TRISTATE_RX_EDGE_CNT_EN)
module tb_tristate_rx;

    localparam int SYNC = 2;
    localparam int FLEN = 3;
    localparam int TURN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pad_in = 1'b0;
    logic local_oe = 1'b1;
    logic evt_ready = 1'b0;
    logic rx_data, rx_valid, evt_valid, evt_rise, evt_overrun;
`ifdef TRISTATE_RX_EDGE_CNT_EN
    logic [15:0] edge_cnt;
`endif

    int checks = 0;
    int failures = 0;

    tristate_rx #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FLEN),
        .TURNAROUND  (TURN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pad_in      (pad_in),
        .local_oe    (local_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_rise    (evt_rise),
        .evt_overrun (evt_overrun)
`ifdef TRISTATE_RX_EDGE_CNT_EN
        ,
        .edge_cnt    (edge_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    bit   hist[$];
    bit   m_sync, m_data, m_evt, m_rise, m_ovr;
    int   m_quiet, m_run;
    logic [15:0] m_cnt;
    bit   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_sync = 0; m_data = 0; m_evt = 0; m_rise = 0; m_ovr = 0;
        m_quiet = 0; m_run = 0; m_cnt = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit p, input bit oe, input bit rdy);
        bit s, edge_now, handshake;
        s = m_sync;
        hist.push_front(p);
        if (hist.size() > SYNC) void'(hist.pop_back());
        m_sync = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
        handshake = m_evt && rdy;
        edge_now = 0;
        // Trusted after one DRIVE-exit edge plus TURN turnaround edges of quiet line.
        if (oe) m_quiet = 0;
        else if (m_quiet < 1000) m_quiet++;
        if (!oe && m_quiet == TURN + 1) begin
            m_data = s;
            m_run = 0;
        end else if (!oe && m_quiet > TURN + 1) begin
            if (s == m_data) m_run = 0;
            else begin
                m_run++;
                if (m_run == FLEN) begin
                    m_data = !m_data;
                    m_run = 0;
                    edge_now = 1;
                end
            end
        end
        if (edge_now) m_cnt = m_cnt + 16'd1;
        if (edge_now && m_evt && !rdy) m_ovr = 1;
        if (handshake) m_ovr = 0;
        if (edge_now && (!m_evt || rdy)) begin
            m_evt = 1;
            m_rise = m_data;
            exp_q.push_back(m_data);
        end else if (handshake) begin
            m_evt = 0;
        end
    endtask

    task automatic compare_all();
        chk("rx_data", rx_data, m_data);
        chk("rx_valid", rx_valid, (m_quiet >= TURN + 1));
        chk("evt_valid", evt_valid, m_evt);
        chk("evt_rise", evt_rise, m_rise);
        chk("evt_overrun", evt_overrun, m_ovr);
`ifdef TRISTATE_RX_EDGE_CNT_EN
        chk("edge_cnt", edge_cnt, m_cnt);
`endif
    endtask

    task automatic tick(input bit p, input bit oe, input bit rdy);
        pad_in = p; local_oe = oe; evt_ready = rdy;
        @(posedge clk);
        #1;
        model_step(p, oe, rdy);
        compare_all();
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_rise", evt_rise, 0);
        chk("rst_evt_overrun", evt_overrun, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Event monitor: pops the scoreboard at every handshake the DUT completes.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", 1, 0);
            end else begin
                chk("evt_pop_rise", evt_rise, exp_q.pop_front());
            end
        end
    end

    initial begin
        int lat;
        bit p, oe;
        int seg;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all();

        // Turnaround: two TURN cycles then LISTEN with preloaded level.
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("turn_not_valid", rx_valid, 0);
        tick(1, 0, 0);
        chk("listen_valid", rx_valid, 1);
        chk("listen_preload", rx_data, 1);
        chk("listen_no_evt", evt_valid, 0);
        repeat (3) tick(1, 0, 0);

        // Step latency: SYNC + FLEN edges.
        lat = 0;
        while (rx_data !== 1'b0 && lat < 20) begin
            tick(0, 0, 0);
            lat++;
        end
        chk("step_latency", lat, SYNC + FLEN);
        chk("fall_evt_valid", evt_valid, 1);
        chk("fall_evt_rise", evt_rise, 0);
        tick(0, 0, 1);
        chk("accept_clears", evt_valid, 0);

        // Short glitches are rejected; a FLEN-long pulse gets through.
        tick(1, 0, 1);
        repeat (6) tick(0, 0, 1);
        repeat (2) tick(1, 0, 1);
        repeat (6) tick(0, 0, 1);
        chk("glitch_data", rx_data, 0);
        chk("glitch_evt", evt_valid, 0);
        repeat (3) tick(1, 0, 1);
        repeat (8) tick(0, 0, 1);

        // Overrun: hold ready low across two edges.
        repeat (4) tick(1, 0, 0);
        repeat (8) tick(0, 0, 0);
        chk("ovr_held_valid", evt_valid, 1);
        chk("ovr_held_rise", evt_rise, 1);
        chk("ovr_flag", evt_overrun, 1);
        tick(0, 0, 1);
        chk("ovr_cleared", evt_overrun, 0);
        tick(0, 0, 0);

        // Reclaim the line mid-filter, then release.
        repeat (4) tick(1, 0, 1);
        tick(1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("reclaim_not_valid", rx_valid, 0);
            tick(1, 0, 1);
        end
        chk("reclaim_valid", rx_valid, 1);
        chk("reclaim_preload", rx_data, 1);
        chk("reclaim_no_evt", evt_valid, 0);

        // Async reset with an event pending.
        repeat (8) tick(0, 0, 0);
        chk("pre_reset_evt", evt_valid, 1);
        do_reset();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            seg = $urandom_range(1, 8);
            p = 1'($urandom_range(0, 1));
            oe = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < seg; i++) begin
                tick(p, oe, ($urandom_range(0, 2) != 0));
            end
            if (k == 200) do_reset();
        end
        repeat (10) tick(p, 0, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
